// File: rtl/axil_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_write_arbiter_if
// Purpose  : AXI4-Lite write-channel bundle (AW, W and B) shared between the
//            write arbiter and the downstream register slave.
// Ports    : master modport drives AWADDR/AWVALID, WDATA/WVALID and BREADY,
//            and samples AWREADY, WREADY, BRESP and BVALID.
//            The slave modport is the mirror image.
// Revision : 1.0  initial release
// ============================================================================
interface axil_write_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WVALID, M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WVALID, M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
endinterface
`default_nettype wire

// File: rtl/axil_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axil_write_arbiter
// Purpose  : Round-robin arbiter sharing one AXI4-Lite write master among
//            NUM_REQ single-beat requesters, with one transaction in flight.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req_valid/addr/data - packed per-requester write requests
//            req_ready         - one-hot combinational grant (IDLE only)
//            done_valid/resp   - one-cycle completion pulse and its BRESP
//            busy              - transaction in flight
//            err_count         - saturating count of non-OKAY responses
//            m_axi             - shared AXI4-Lite write master port
// Revision : 1.0  initial release
// ============================================================================
module axil_write_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            done_valid,
  output logic [1:0]                    done_resp,
  output logic                          busy,
  output logic [ERR_CNT_WIDTH-1:0]      err_count,
  axil_write_arbiter_if.master          m_axi
);

  localparam int                 c_idx_w   = $clog2(NUM_REQ);
  localparam logic [c_idx_w:0]   c_num_req = (c_idx_w+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                   r_state,      w_state_nxt;
  logic [c_idx_w-1:0]       r_last_grant, w_last_grant_nxt;
  logic [c_idx_w-1:0]       r_owner,      w_owner_nxt;
  logic [ADDR_WIDTH-1:0]    r_awaddr,     w_awaddr_nxt;
  logic                     r_awvalid,    w_awvalid_nxt;
  logic [DATA_WIDTH-1:0]    r_wdata,      w_wdata_nxt;
  logic                     r_wvalid,     w_wvalid_nxt;
  logic                     r_bready,     w_bready_nxt;
  logic [NUM_REQ-1:0]       r_done_valid, w_done_valid_nxt;
  logic [1:0]               r_done_resp,  w_done_resp_nxt;
  logic                     r_busy,       w_busy_nxt;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt,    w_err_cnt_nxt;

  logic                     w_found;
  logic [c_idx_w-1:0]       w_grant_idx;
  logic [NUM_REQ-1:0]       w_grant;
  logic                     w_accept;

  // Round-robin search starting just after the last grant. The candidate
  // index is wrapped with a compare/subtract so non-power-of-two counts work.
  always_comb begin
    logic [c_idx_w:0] w_sum;
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last_grant} + (c_idx_w+1)'(k);
      if (w_sum >= c_num_req) w_sum = w_sum - c_num_req;
      if (!w_found && req_valid[w_sum[c_idx_w-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_sum[c_idx_w-1:0];
      end
    end
    w_grant = w_found ? (NUM_REQ'(1) << w_grant_idx) : '0;
  end

  assign w_accept  = (r_state == ST_IDLE) && !rst && w_found;
  assign req_ready = ((r_state == ST_IDLE) && !rst) ? w_grant : '0;

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_owner_nxt      = r_owner;
    w_awaddr_nxt     = r_awaddr;
    w_awvalid_nxt    = r_awvalid;
    w_wdata_nxt      = r_wdata;
    w_wvalid_nxt     = r_wvalid;
    w_bready_nxt     = r_bready;
    w_done_valid_nxt = '0;
    w_done_resp_nxt  = '0;
    w_busy_nxt       = r_busy;
    w_err_cnt_nxt    = r_err_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_awaddr_nxt     = req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          w_wdata_nxt      = req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
          w_awvalid_nxt    = 1'b1;
          w_wvalid_nxt     = 1'b1;
          w_owner_nxt      = w_grant_idx;
          w_last_grant_nxt = w_grant_idx;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = ST_XFER;
        end
      end
      ST_XFER: begin
        // AW and W complete independently; move on once neither is pending.
        if (m_axi.M_AXI_AWREADY) w_awvalid_nxt = 1'b0;
        if (m_axi.M_AXI_WREADY)  w_wvalid_nxt  = 1'b0;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi.M_AXI_BVALID) begin
          w_bready_nxt     = 1'b0;
          w_done_valid_nxt = NUM_REQ'(1) << r_owner;
          w_done_resp_nxt  = m_axi.M_AXI_BRESP;
          w_busy_nxt       = 1'b0;
          w_state_nxt      = ST_IDLE;
          if (m_axi.M_AXI_BRESP != 2'b00 && r_err_cnt != '1)
            w_err_cnt_nxt = r_err_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_bready_nxt  = 1'b0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= c_idx_w'(NUM_REQ-1);
      r_owner      <= '0;
      r_awaddr     <= '0;
      r_awvalid    <= 1'b0;
      r_wdata      <= '0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_done_valid <= '0;
      r_done_resp  <= '0;
      r_busy       <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_awaddr     <= w_awaddr_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_bready     <= w_bready_nxt;
      r_done_valid <= w_done_valid_nxt;
      r_done_resp  <= w_done_resp_nxt;
      r_busy       <= w_busy_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign done_valid          = r_done_valid;
  assign done_resp           = r_done_resp;
  assign busy                = r_busy;
  assign err_count           = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axil_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_write_arbiter
// Purpose  : Randomized self-checking bench for axil_write_arbiter with a
//            transaction-level reference model (round-robin pick, handshake
//            tracking, saturating error count).
// Revision : 1.0  initial release
// ============================================================================
module tb_axil_write_arbiter;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int ERR_W = 2;
  localparam int c_err_max = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      done_valid;
  logic [1:0]        done_resp;
  logic              busy;
  logic [ERR_W-1:0]  err_count;

  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];

  int n_checks = 0;
  int n_fail   = 0;
  int m_last;
  int m_err;

  axil_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axil_write_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(ERR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .done_valid(done_valid), .done_resp(done_resp),
    .busy(busy), .err_count(err_count), .m_axi(axi.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr_a[i];
      req_data[i*DW +: DW] = data_a[i];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: first valid requester after the last grant.
  function automatic int model_grant(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  // One request round, starting just after a clock edge in IDLE.
  task automatic do_txn(input logic [N-1:0] mask, input int aw_d, input int w_d,
                        input int b_d, input logic [1:0] resp);
    int w;
    int cyc;
    logic exp_awv, exp_wv;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    req_valid = mask;
    #1;
    w = model_grant(mask);
    check_val("grant", req_ready, (w < 0) ? '0 : oh(w));
    if (w < 0) begin
      @(posedge clk); #1;
      check_val("idle_busy", busy, 0);
      check_val("idle_awvalid", axi.M_AXI_AWVALID, 0);
      return;
    end
    ea = addr_a[w];
    ed = data_a[w];
    m_last = w;
    @(posedge clk); #1;
    exp_awv = 1'b1;
    exp_wv  = 1'b1;
    cyc = 0;
    while ((exp_awv || exp_wv) && cyc < 40) begin
      axi.M_AXI_AWREADY = (cyc >= aw_d);
      axi.M_AXI_WREADY  = (cyc >= w_d);
      check_val("awvalid", axi.M_AXI_AWVALID, exp_awv);
      check_val("wvalid", axi.M_AXI_WVALID, exp_wv);
      if (exp_awv) check_val("awaddr", axi.M_AXI_AWADDR, ea);
      if (exp_wv)  check_val("wdata", axi.M_AXI_WDATA, ed);
      check_val("bready_xfer", axi.M_AXI_BREADY, 0);
      check_val("busy_xfer", busy, 1);
      check_val("ready_xfer", req_ready, 0);
      check_val("done_xfer", done_valid, 0);
      @(posedge clk); #1;
      if (axi.M_AXI_AWREADY) exp_awv = 1'b0;
      if (axi.M_AXI_WREADY)  exp_wv  = 1'b0;
      cyc++;
    end
    check_val("xfer_bound", {exp_awv, exp_wv}, 0);
    axi.M_AXI_AWREADY = 1'b0;
    axi.M_AXI_WREADY  = 1'b0;
    for (int c = 0; c < b_d; c++) begin
      check_val("bready_wait", axi.M_AXI_BREADY, 1);
      check_val("valids_resp", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID}, 0);
      check_val("done_wait", done_valid, 0);
      @(posedge clk); #1;
    end
    axi.M_AXI_BVALID = 1'b1;
    axi.M_AXI_BRESP  = resp;
    check_val("bready", axi.M_AXI_BREADY, 1);
    @(posedge clk); #1;
    axi.M_AXI_BVALID = 1'b0;
    axi.M_AXI_BRESP  = 2'b00;
    if (resp != 2'b00 && m_err < c_err_max) m_err++;
    check_val("done_valid", done_valid, oh(w));
    check_val("done_resp", done_resp, resp);
    check_val("busy_done", busy, 0);
    check_val("bready_done", axi.M_AXI_BREADY, 0);
    check_val("err_count", err_count, m_err);
  endtask

  task automatic refresh(input int i);
    addr_a[i] = $urandom;
    data_a[i] = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) refresh(i);
    axi.M_AXI_AWREADY = 1'b0;
    axi.M_AXI_WREADY  = 1'b0;
    axi.M_AXI_BVALID  = 1'b0;
    axi.M_AXI_BRESP   = 2'b00;
    m_last = N - 1;
    m_err  = 0;

    // Reset values; grants must stay off while rst is high.
    repeat (3) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    check_val("rst_ready", req_ready, 0);
    check_val("rst_outs", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, busy}, 0);
    check_val("rst_addr", axi.M_AXI_AWADDR, 0);
    check_val("rst_data", axi.M_AXI_WDATA, 0);
    check_val("rst_done", {done_valid, done_resp}, 0);
    check_val("rst_err", err_count, 0);
    req_valid = '0;
    rst = 1'b0;

    // Single request with the slave ready immediately.
    addr_a[2] = 32'h4000_0004;
    data_a[2] = 32'h0000_1230;
    do_txn(4'b0100, 0, 0, 0, 2'b00);
    refresh(2);

    // Fairness from a fresh reset: all requesters held valid.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = N - 1;
    m_err  = 0;
    for (int t = 0; t < 8; t++) begin
      do_txn('1, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 2'b00);
      refresh(m_last);
    end

    // W handshake three cycles ahead of AW, then both on the same edge.
    do_txn(4'b1001, 3, 0, 1, 2'b00);
    do_txn(4'b0110, 1, 1, 0, 2'b00);

    // Error responses drive the 2-bit counter into saturation.
    for (int t = 0; t < 5; t++) begin
      do_txn(N'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 2), 0, 2'b10);
      refresh(m_last);
    end

    // Reset in the middle of a transfer.
    req_valid = 4'b0001;
    #1;
    check_val("mid_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    check_val("mid_awvalid", axi.M_AXI_AWVALID, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    axi.M_AXI_BVALID = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = N - 1;
    m_err  = 0;
    check_val("post_rst_valids", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}, 0);
    check_val("post_rst_addr", axi.M_AXI_AWADDR, 0);
    check_val("post_rst_data", axi.M_AXI_WDATA, 0);
    check_val("post_rst_misc", {done_valid, done_resp, busy, err_count}, 0);
    for (int c = 0; c < 3; c++) begin
      check_val("post_rst_nodone", {done_valid, axi.M_AXI_BREADY}, 0);
      @(posedge clk); #1;
    end
    axi.M_AXI_BVALID = 1'b0;
    do_txn(4'b1010, 0, 1, 0, 2'b00);
    do_txn(4'b1010, 1, 0, 0, 2'b00);

    // Randomized traffic, including empty request cycles.
    for (int t = 0; t < 40; t++) begin
      do_txn(N'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 3), 2'($urandom_range(0, 3)));
      if (m_last >= 0) refresh(m_last);
    end

    req_valid = '0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
